// File: rtl/csa_accumulator_pkg.sv
// Shared types and helpers for the carry-save streaming accumulator.
// Holds the FSM state encoding, default sizing and a width-generic sign extender.
package csa_accumulator_pkg;

  localparam int DEFAULT_N       = 32;
  localparam int DEFAULT_MAX_OPS = 16;
  localparam int EXT_MAX         = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Replicates bit (width-1) into every higher position; callers cast down to their own width.
  function automatic logic [EXT_MAX-1:0] signExtend(input logic [EXT_MAX-1:0] value,
                                                    input int width);
    logic [EXT_MAX-1:0] result;
    result = '0;
    for (int i = 0; i < EXT_MAX; i++) begin
      result[i] = (i < width) ? value[i] : value[width-1];
    end
    return result;
  endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand/result handshake bundle between an upstream producer, the accumulator and its consumer.
// The master side drives operands and out_ready; the slave side is the accumulator.
interface csa_accumulator_if
  import csa_accumulator_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int GUARD = $clog2(DEFAULT_MAX_OPS)
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic           in_last;
  logic           cin;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_sum;
  logic           out_OF;
  logic [GUARD:0] out_ops;
  logic           out_trunc;

  modport master (
    output in_valid, in_data, in_last, cin, out_ready,
    input  in_ready, out_valid, out_sum, out_OF, out_ops, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, cin, out_ready,
    output in_ready, out_valid, out_sum, out_OF, out_ops, out_trunc
  );

endinterface

// File: rtl/carry_select_adder.sv
// W-bit carry-select adder: each BLK-bit slice precomputes its sum for both
// carry-in values and the incoming block carry picks one.
module carry_select_adder #(
  parameter int W   = 32,
  parameter int BLK = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum
);

  localparam int NB = (W + BLK - 1) / BLK;
  localparam int WP = NB * BLK;

  logic [WP-1:0] w_a;
  logic [WP-1:0] w_b;
  logic [WP-1:0] w_sum;
  logic [NB-1:0] w_carry;

  assign w_a        = WP'(i_a);
  assign w_b        = WP'(i_b);
  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < NB; g++) begin : gBlock
    if (g < NB - 1) begin : gMid
      logic [BLK:0] w_sum0;
      logic [BLK:0] w_sum1;
      assign w_sum0 = {1'b0, w_a[g*BLK +: BLK]} + {1'b0, w_b[g*BLK +: BLK]};
      assign w_sum1 = {1'b0, w_a[g*BLK +: BLK]} + {1'b0, w_b[g*BLK +: BLK]} + (BLK+1)'(1);
      assign w_sum[g*BLK +: BLK] = w_carry[g] ? w_sum1[BLK-1:0] : w_sum0[BLK-1:0];
      assign w_carry[g+1]        = w_carry[g] ? w_sum1[BLK] : w_sum0[BLK];
    end else begin : gTop
      // The top slice has no carry-out consumer, so it is built BLK bits wide.
      logic [BLK-1:0] w_top0;
      logic [BLK-1:0] w_top1;
      assign w_top0 = w_a[g*BLK +: BLK] + w_b[g*BLK +: BLK];
      assign w_top1 = w_a[g*BLK +: BLK] + w_b[g*BLK +: BLK] + BLK'(1);
      assign w_sum[g*BLK +: BLK] = w_carry[g] ? w_top1 : w_top0;
    end
  end

  assign o_sum = w_sum[W-1:0];

endmodule

// File: rtl/csa_accumulator_csa_row.sv
// One 3:2 compressor row: reduces three W-bit vectors to a sum vector and an
// unshifted majority (carry) vector. Purely combinational.
module csa_row #(
  parameter int W = 36
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_m
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_m = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/csa_accumulator.sv
// Streaming signed multi-operand accumulator: keeps the running total in carry-save
// form and resolves it once per burst through a carry-select adder.
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int MAX_OPS = DEFAULT_MAX_OPS,
  parameter int GUARD   = $clog2(MAX_OPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  csa_accumulator_if.slave    bus
);

  localparam int             W         = N + GUARD;
  localparam logic [GUARD:0] OPS_ONE   = (GUARD+1)'(1);
  localparam logic [GUARD:0] OPS_LIMIT = (GUARD+1)'(MAX_OPS);

  state_t         r_state;
  logic [W-1:0]   r_s;
  logic [W-1:0]   r_c;
  logic [GUARD:0] r_cnt;
  logic           r_truncPend;
  logic           r_inReady;
  logic           r_outValid;
  logic [N-1:0]   r_sum;
  logic           r_of;
  logic [GUARD:0] r_ops;
  logic           r_trunc;

  logic           w_accept;
  logic [W-1:0]   w_x;
  logic [W-1:0]   w_cinVec;
  logic [W-1:0]   w_s;
  logic [W-1:0]   w_m;
  logic [W-1:0]   w_r;
  logic [GUARD:0] w_cntNext;
  logic [GUARD:0] w_hi;
  logic           w_overflow;

  assign w_accept  = bus.in_valid & r_inReady;
  assign w_x       = W'(signExtend(EXT_MAX'(bus.in_data), N));
  assign w_cinVec  = {{(W-1){1'b0}}, bus.cin};
  assign w_cntNext = r_cnt + OPS_ONE;

  csa_row #(.W(W)) uRow (
    .i_a (r_s),
    .i_b (r_c),
    .i_c (w_x),
    .o_s (w_s),
    .o_m (w_m)
  );

  carry_select_adder #(.W(W)) uAdder (
    .i_a   (r_s),
    .i_b   (r_c),
    .i_cin (1'b0),
    .o_sum (w_r)
  );

  // The guard bits plus the N-bit sign bit must all agree for the sum to fit in N bits.
  assign w_hi       = w_r[W-1:N-1];
  assign w_overflow = ~((&w_hi) | (~|w_hi));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
      r_truncPend <= 1'b0;
      r_inReady   <= 1'b1;
      r_outValid  <= 1'b0;
      r_sum       <= '0;
      r_of        <= 1'b0;
      r_ops       <= '0;
      r_trunc     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s         <= w_x;
            r_c         <= w_cinVec;
            r_cnt       <= OPS_ONE;
            r_truncPend <= 1'b0;
            if (bus.in_last) begin
              r_state   <= RESOLVE;
              r_inReady <= 1'b0;
            end else begin
              r_state   <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_s   <= w_s;
            r_c   <= w_m << 1;
            r_cnt <= w_cntNext;
            if (bus.in_last || (w_cntNext == OPS_LIMIT)) begin
              r_state     <= RESOLVE;
              r_inReady   <= 1'b0;
              r_truncPend <= ~bus.in_last;
            end
          end
        end
        RESOLVE: begin
          r_sum      <= w_r[N-1:0];
          r_of       <= w_overflow;
          r_ops      <= r_cnt;
          r_trunc    <= r_truncPend;
          r_outValid <= 1'b1;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_sum   = r_sum;
  assign bus.out_OF    = r_of;
  assign bus.out_ops   = r_ops;
  assign bus.out_trunc = r_trunc;

endmodule
